// File: rtl/counter_pkg.sv
// counter_pkg: shared saturation-mode constants and prescaler width helper.
package counter_pkg;
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;
    function automatic int prescale_width(input int p);
        return (p <= 2) ? 1 : $clog2(p);
    endfunction
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: counts enabled cycles and pulses tick on every PRESCALE-th one.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic ena,
    input  logic clear,
    output logic tick
);
    localparam int PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = ena && (cnt_q == LAST);
        cnt_d = tick ? '0 : ena ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset || clear) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/prescaled_updown_counter.sv
// prescaled_updown_counter: modulo up/down counter with prescaler, wrap/saturate, tc pulse and sticky overflow.
module prescaled_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 8,
    parameter longint MODULO   = 256,
    parameter int     PRESCALE = 1,
    parameter int     SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] result,
    output logic             tc,
    output logic             overflow
);
    if (WIDTH < 2 || WIDTH > 32 || MODULO < 2 || MODULO > (longint'(1) << WIDTH) ||
        PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_params
        $fatal(1, "prescaled_updown_counter: illegal WIDTH/MODULO/PRESCALE");
    end
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
    localparam bit SAT = (SATURATE == MODE_SAT);
    logic [WIDTH-1:0] result_q, result_d, step_val, load_val;
    logic tc_q, tc_d, ovf_q, ovf_d, tick, at_top, at_bot, at_bound;
    counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .clear (clear || load),
        .tick  (tick)
    );
    // Bounds are compared explicitly so MODULO below 2^WIDTH wraps at the right place.
    always_comb begin
        at_top   = (result_q == MAX);
        at_bot   = (result_q == '0);
        at_bound = up ? at_top : at_bot;
        step_val = up ? (at_top ? (SAT ? result_q : '0) : result_q + 1'b1)
                      : (at_bot ? (SAT ? result_q : MAX) : result_q - 1'b1);
        load_val = (load_value > MAX) ? MAX : load_value;
        result_d = clear ? '0 : load ? load_val : tick ? step_val : result_q;
        tc_d     = !clear && !load && tick && at_bound;
        ovf_d    = tc_d || (ovf_q && !ovf_clr);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            tc_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            tc_q     <= tc_d;
            ovf_q    <= ovf_d;
        end
    end
    assign result   = result_q;
    assign tc       = tc_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_prescaled_updown_counter.sv
// tb_prescaled_updown_counter: random stimulus on a wrapping and a saturating instance, scoreboard-checked.
module tb_prescaled_updown_counter;
    localparam int M  = 10;
    localparam int PW = 3;
    localparam int PS = 1;

    logic clk = 0, reset = 1, ena = 0, up = 1, clear = 0, load = 0, ovf_clr = 0;
    logic [4:0] load_value = '0;
    logic [4:0] res_w, res_s;
    logic tc_w, tc_s, ovf_w, ovf_s;

    always #5 clk = ~clk;

    prescaled_updown_counter #(.WIDTH(5), .MODULO(M), .PRESCALE(PW), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .ena(ena), .up(up), .clear(clear), .load(load),
        .load_value(load_value), .ovf_clr(ovf_clr), .result(res_w), .tc(tc_w), .overflow(ovf_w));

    prescaled_updown_counter #(.WIDTH(5), .MODULO(M), .PRESCALE(PS), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .ena(ena), .up(up), .clear(clear), .load(load),
        .load_value(load_value), .ovf_clr(ovf_clr), .result(res_s), .tc(tc_s), .overflow(ovf_s));

    typedef struct {
        int rw; bit tw; bit ow;
        int rs; bit ts; bit os;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0;

    function automatic void model(input bit sat, input int p, inout int cnt, inout int pre,
                                  inout bit t, inout bit o, input bit rst, input bit clr,
                                  input bit ld, input bit en, input bit u, input bit oc, input int lv);
        int nxt;
        if (rst) begin
            cnt = 0; pre = 0; t = 0; o = 0;
            return;
        end
        t = 0;
        if (clr) begin
            cnt = 0; pre = 0;
        end else if (ld) begin
            cnt = (lv > M - 1) ? M - 1 : lv; pre = 0;
        end else if (en) begin
            pre++;
            if (pre == p) begin
                pre = 0;
                nxt = cnt + (u ? 1 : -1);
                if (nxt < 0 || nxt >= M) begin
                    t = 1;
                    if (!sat) cnt = (nxt + M) % M;
                end else cnt = nxt;
            end
        end
        o = t || (o && !oc);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("wrap.result",   int'(res_w), e.rw);
                check("wrap.tc",       int'(tc_w),  int'(e.tw));
                check("wrap.overflow", int'(ovf_w), int'(e.ow));
                check("sat.result",    int'(res_s), e.rs);
                check("sat.tc",        int'(tc_s),  int'(e.ts));
                check("sat.overflow",  int'(ovf_s), int'(e.os));
            end
        end
    end

    initial begin
        int cw = 0, pw = 0, cs = 0, ps = 0;
        bit tw = 0, ow = 0, ts = 0, os = 0;
        exp_t e;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset      = (i < 2) || ($urandom_range(99) == 0);
            clear      = ($urandom_range(29) == 0);
            load       = ($urandom_range(15) == 0);
            ena        = ($urandom_range(9) < 8);
            ovf_clr    = ($urandom_range(7) == 0);
            load_value = 5'($urandom_range(31));
            if ($urandom_range(14) == 0) up = ~up;
            model(0, PW, cw, pw, tw, ow, reset, clear, load, ena, up, ovf_clr, int'(load_value));
            model(1, PS, cs, ps, ts, os, reset, clear, load, ena, up, ovf_clr, int'(load_value));
            e.rw = cw; e.tw = tw; e.ow = ow;
            e.rs = cs; e.ts = ts; e.os = os;
            q.push_back(e);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prescaled_updown_counter.md
PRESCALED_UPDOWN_COUNTER -- requirements
Module: prescaled_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits (2..32).
REQ-002 The block SHALL have parameter MODULO, default 256, count range 0..MODULO-1 (2..2^WIDTH).
REQ-003 The block SHALL have parameter PRESCALE, default 1, the number of enabled cycles per count step (1..65536).
REQ-004 The block SHALL have parameter SATURATE, default 0, bound behaviour: 0 = wrap, 1 = hold at bound.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port ena, input, 1, count enable; low freezes the counter and prescaler.
REQ-008 The block SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-009 The block SHALL have port clear, input, 1, synchronous clear of the count and prescaler.
REQ-010 The block SHALL have port load, input, 1, synchronous load of load_value.
REQ-011 The block SHALL have port load_value, input, WIDTH, the value to load.
REQ-012 The block SHALL have port ovf_clr, input, 1, clears the sticky overflow flag.
REQ-013 The block SHALL have port result, output, WIDTH, the registered count.
REQ-014 The block SHALL have port tc, output, 1, a registered one-cycle terminal-count pulse.
REQ-015 The block SHALL have port overflow, output, 1, a sticky flag set by any tc.

Function
REQ-016 Per-edge priority SHALL be: reset > clear > load > count step; a lower-priority action is ignored when a higher one is active.
REQ-017 The prescaler SHALL count cycles with ena=1 through 0..PRESCALE-1, and tick is asserted when ena=1 and the prescaler equals PRESCALE-1; the prescaler then returns to 0.
REQ-018 With PRESCALE=1, tick SHALL equal ena, giving one step per enabled cycle.
REQ-019 A count step SHALL occur on an edge where tick=1; up is sampled on that edge only.
REQ-020 The step latency SHALL be one cycle: result shows the new value in the cycle after the stepping edge.
REQ-021 When up=1 and result=MODULO-1 with SATURATE=0, the next value SHALL be 0; when up=0 and result=0, the next value SHALL be MODULO-1.
REQ-022 With SATURATE=1, a step that would pass a bound SHALL leave result unchanged.
REQ-023 tc SHALL be 1 for exactly the cycle after any step taken at a bound (a wrap, or a held saturating step), and 0 otherwise.
REQ-024 overflow SHALL be set on the edge on which tc is registered high, and it is cleared by ovf_clr; if both happen on the same edge, the set wins.
REQ-025 load SHALL write min(load_value, MODULO-1) to result, zero the prescaler and force tc to 0.
REQ-026 clear SHALL write 0 to result, zero the prescaler and force tc to 0, and SHALL NOT affect overflow.
REQ-027 The count arithmetic SHALL be in WIDTH bits with explicit bound compares and no reliance on natural 2^WIDTH overflow, so MODULO < 2^WIDTH is handled correctly.

Reset
REQ-028 On reset=1 at a clock edge, result, the prescaler, tc and overflow SHALL all become 0.
REQ-029 A reset asserted mid-prescale or mid-operation SHALL discard the partial prescale count, and the first step after release SHALL require a full PRESCALE enabled cycles.

Structure
REQ-030 A shared package counter_pkg SHALL hold the SATURATE mode constants (MODE_WRAP=0, MODE_SAT=1) and a function computing the prescaler width, clog2(PRESCALE) with a minimum of 1.
REQ-031 The prescaler SHALL be a separate sub-module, counter_prescaler (ports clk, reset, ena, clear, tick).
REQ-032 Parameter legality (the MODULO range and PRESCALE>=1) SHALL be checked at elaboration, and an illegal value SHALL be a fatal error.

Verification
REQ-033 With defaults, reset for 2 cycles, then ena=1, up=1 for 260 cycles: result goes 0..255, then 0..3; tc is high for exactly one cycle, the one in which result=0 after 255; overflow=1.
REQ-034 With MODULO=10, up=0 from result=0: result=9 the next cycle with tc=1, then counts 8, 7, ...; then ovf_clr=1 gives overflow=0.
REQ-035 With PRESCALE=4, ena=1 for 12 cycles: result steps 0, 1, 2, 3, once every 4 cycles; dropping ena for 3 cycles mid-prescale delays the next step by exactly 3 cycles.
REQ-036 With SATURATE=1 and MODULO=10: load load_value=200 gives result=9; a further up step keeps result=9 with tc=1; a down step from 0 keeps result=0 with tc=1.
REQ-037 Simultaneous events: clear=1 and load=1 on the same edge gives result=0; load at a wrap edge loads with tc=0; ovf_clr coinciding with tc leaves overflow=1; reset mid-count gives all outputs 0 on the next cycle.
